// File: rtl/tm1638_frame_ctrl.sv
// TM1638 frame sequencer: snapshots display state on refresh and pushes a full
// command frame (plus optional key scan) into the spi_fifo write port.
module tm1638_frame_ctrl #(
  parameter int KEY_READ_EN         = 1,
  parameter int READ_TIMEOUT_CYCLES = 4096
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Refresh,
  input  logic [63:0] i_Digits,
  input  logic [7:0]  i_Leds,
  input  logic [2:0]  i_Brightness,
  input  logic        i_Display_On,
  input  logic        i_FIFO_Full,
  output logic        o_Data_Valid,
  output logic [17:0] o_Data,
  input  logic        i_Read_Valid,
  input  logic [31:0] i_Key_Data,
  output logic [7:0]  o_Keys,
  output logic        o_Keys_Valid,
  output logic        o_Read_Timeout,
  output logic        o_Busy
);

  localparam logic [4:0] NUM_WORDS = (KEY_READ_EN != 0) ? 5'd20 : 5'd19;
  localparam int CNT_W = $clog2(READ_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, PUSH, GAP, WAIT_KEYS, DONE} state_t;

  state_t           state_reg, state_next;
  logic [4:0]       index_reg, index_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pending_reg, pending_next;
  logic             busy_reg, busy_next;
  logic             data_valid_reg, data_valid_next;
  logic [17:0]      data_reg, data_next;
  logic [7:0]       keys_reg, keys_next;
  logic             keys_valid_reg, keys_valid_next;
  logic             timeout_reg, timeout_next;
  logic [63:0]      digits_reg;
  logic [7:0]       leds_reg;
  logic [7:0]       ctrl_reg;

  logic [7:0]  disp_bytes [16];
  logic [7:0]  key_decode;
  logic [3:0]  byte_sel;
  logic [17:0] word;
  logic        unused_key_bits;

  // Display payload interleaves digit byte k with LED k.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_disp
      assign disp_bytes[2*gi]     = digits_reg[8*gi +: 8];
      assign disp_bytes[2*gi + 1] = {7'b0, leds_reg[gi]};
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_keys
      assign key_decode[gi]     = i_Key_Data[8*gi];
      assign key_decode[gi + 4] = i_Key_Data[8*gi + 4];
    end
  endgenerate

  assign unused_key_bits = ^{i_Key_Data[31:29], i_Key_Data[27:25], i_Key_Data[23:21],
                             i_Key_Data[19:17], i_Key_Data[15:13], i_Key_Data[11:9],
                             i_Key_Data[7:5], i_Key_Data[3:1]};

  // Words 2..17 map onto disp_bytes 0..15; the 4-bit wrap handles 16 and 17.
  assign byte_sel = index_reg[3:0] - 4'd2;

  always_comb begin
    word = 18'h0;
    if (index_reg == 5'd0)
      word = {2'b10, 8'h00, 8'h40};
    else if (index_reg == 5'd1)
      word = {2'b00, 8'h00, 8'hC0};
    else if (index_reg <= 5'd17)
      word = {(index_reg == 5'd17), 1'b0, 8'h00, disp_bytes[byte_sel]};
    else if (index_reg == 5'd18)
      word = {2'b10, 8'h00, ctrl_reg};
    else
      word = {2'b11, 8'h00, 8'h42};
  end

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    cnt_next        = cnt_reg;
    pending_next    = pending_reg | (i_Refresh && (state_reg != IDLE));
    busy_next       = busy_reg;
    data_valid_next = 1'b0;
    data_next       = data_reg;
    keys_next       = keys_reg;
    keys_valid_next = 1'b0;
    timeout_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        index_next = 5'd0;
        if (i_Refresh || pending_reg)
          state_next = START;
      end
      START: begin
        busy_next    = 1'b1;
        pending_next = i_Refresh;
        state_next   = i_FIFO_Full ? GAP : PUSH;
      end
      PUSH: begin
        index_next = index_reg + 5'd1;
        state_next = GAP;
      end
      GAP: begin
        if (index_reg == NUM_WORDS) begin
          cnt_next   = '0;
          state_next = (KEY_READ_EN != 0) ? WAIT_KEYS : DONE;
        end else if (!i_FIFO_Full) begin
          state_next = PUSH;
        end
      end
      WAIT_KEYS: begin
        if (i_Read_Valid) begin
          keys_next       = key_decode;
          keys_valid_next = 1'b1;
          state_next      = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Output word is registered so o_Data_Valid is high exactly while in PUSH.
    if (state_next == PUSH) begin
      data_valid_next = 1'b1;
      data_next       = word;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg      <= IDLE;
      index_reg      <= '0;
      cnt_reg        <= '0;
      pending_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      data_valid_reg <= 1'b0;
      data_reg       <= '0;
      keys_reg       <= '0;
      keys_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      digits_reg     <= '0;
      leds_reg       <= '0;
      ctrl_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      cnt_reg        <= cnt_next;
      pending_reg    <= pending_next;
      busy_reg       <= busy_next;
      data_valid_reg <= data_valid_next;
      data_reg       <= data_next;
      keys_reg       <= keys_next;
      keys_valid_reg <= keys_valid_next;
      timeout_reg    <= timeout_next;
      if (state_reg == START) begin
        digits_reg <= i_Digits;
        leds_reg   <= i_Leds;
        ctrl_reg   <= i_Display_On ? {5'b10001, i_Brightness} : 8'h80;
      end
    end
  end

  assign o_Data_Valid   = data_valid_reg;
  assign o_Data         = data_reg;
  assign o_Keys         = keys_reg;
  assign o_Keys_Valid   = keys_valid_reg;
  assign o_Read_Timeout = timeout_reg;
  assign o_Busy         = busy_reg;

endmodule
